// File: rtl/paged_bx_memory_if.sv
// Bus bundle for paged_bx_memory: append port A, read port B and status flags.
interface paged_bx_memory_if #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned RAM_DEPTH = 16,
  parameter int unsigned PAGES     = 2,
  parameter int unsigned BX_WIDTH  = 3
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned NW = AW + 1;

  logic [BX_WIDTH-1:0]  bx_a;
  logic                 wea;
  logic [RAM_WIDTH-1:0] dina;
  logic [BX_WIDTH-1:0]  bx_b;
  logic                 enb;
  logic [AW-1:0]        addrb;
  logic                 regceb;
  logic [RAM_WIDTH-1:0] doutb;
  logic                 validb;
  logic [NW-1:0]        nent_b;
  logic [NW-1:0]        nent_a;
  logic                 full_a;
  logic                 overflow;

  modport master (
    output bx_a, wea, dina, bx_b, enb, addrb, regceb,
    input  doutb, validb, nent_b, nent_a, full_a, overflow
  );

  modport slave (
    input  bx_a, wea, dina, bx_b, enb, addrb, regceb,
    output doutb, validb, nent_b, nent_a, full_a, overflow
  );
endinterface

// File: rtl/paged_bx_memory.sv
// Paged append-only memory: one entry counter per BX page, writes append at the
// page counter, reads report whether the address holds a written entry.
module paged_bx_memory #(
  parameter int unsigned RAM_WIDTH       = 32,
  parameter int unsigned RAM_DEPTH       = 16,
  parameter int unsigned PAGES           = 2,
  parameter int unsigned BX_WIDTH        = 3,
  parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input logic              clk,
  input logic              reset,
  paged_bx_memory_if.slave bus
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned PW = $clog2(PAGES);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned MW = PW + AW;
  localparam logic [NW-1:0] FULL_CNT = NW'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [PAGES*RAM_DEPTH];
  logic [NW-1:0]        cnt_q [PAGES];
  logic [NW-1:0]        cnt_d [PAGES];
  logic [BX_WIDTH-1:0]  bx_a_q;
  logic                 overflow_q;
  logic                 overflow_d;
  logic [RAM_WIDTH-1:0] ram_q;
  logic                 ram_v_q;

  logic [PW-1:0] wpage;
  logic [PW-1:0] rpage;
  logic          new_bx;
  logic [NW-1:0] wr_cnt;
  logic          do_write;
  logic [MW-1:0] waddr;
  logic [MW-1:0] raddr;
  logic          unused_bits;

  assign wpage    = bus.bx_a[PW-1:0];
  assign rpage    = bus.bx_b[PW-1:0];
  assign new_bx   = (bus.bx_a != bx_a_q);
  // A fresh BX restarts its page from zero in the same cycle.
  assign wr_cnt   = new_bx ? '0 : cnt_q[wpage];
  assign do_write = bus.wea && (wr_cnt < FULL_CNT);
  assign waddr    = {wpage, wr_cnt[AW-1:0]};
  assign raddr    = {rpage, bus.addrb};

  assign unused_bits = ^{bus.bx_b, bus.regceb};

  // Counter and overflow next state.
  always_comb begin
    for (int p = 0; p < PAGES; p++) cnt_d[p] = cnt_q[p];
    overflow_d = overflow_q;
    if (new_bx) begin
      cnt_d[wpage] = '0;
      overflow_d   = 1'b0;
    end
    if (do_write) begin
      cnt_d[wpage] = wr_cnt + NW'(1);
    end else if (bus.wea) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < PAGES; p++) cnt_q[p] <= '0;
      bx_a_q     <= '0;
      overflow_q <= 1'b0;
      ram_q      <= '0;
      ram_v_q    <= 1'b0;
    end else begin
      for (int p = 0; p < PAGES; p++) cnt_q[p] <= cnt_d[p];
      bx_a_q     <= bus.bx_a;
      overflow_q <= overflow_d;
      if (bus.enb) begin
        ram_q   <= mem[raddr];
        ram_v_q <= (NW'(bus.addrb) < cnt_q[rpage]);
      end else begin
        ram_v_q <= 1'b0;
      end
    end
  end

  // Storage array is not reset; reads see the pre-write contents.
  always_ff @(posedge clk) begin
    if (do_write) mem[waddr] <= bus.dina;
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_ll
    assign bus.doutb  = ram_q;
    assign bus.validb = ram_v_q;
  end else begin : g_hp
    logic [RAM_WIDTH-1:0] out_q;
    logic                 out_v_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_q   <= '0;
        out_v_q <= 1'b0;
      end else if (bus.regceb) begin
        out_q   <= ram_q;
        out_v_q <= ram_v_q;
      end
    end

    assign bus.doutb  = out_q;
    assign bus.validb = out_v_q;
  end

  assign bus.nent_a   = wr_cnt;
  assign bus.full_a   = (wr_cnt == FULL_CNT);
  assign bus.nent_b   = cnt_q[rpage];
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_paged_bx_memory.sv
// Directed bench for paged_bx_memory; HIGH_PERFORMANCE and LOW_LATENCY copies
// run the same stimulus against one behavioural model.
module tb_paged_bx_memory;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int P  = 2;
  localparam int BW = 3;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] bx_a_r, bx_b_r;
  logic          wea_r, enb_r, regceb_r;
  logic [W-1:0]  dina_r;
  logic [3:0]    addrb_r;

  int n_checks = 0;
  int n_fail   = 0;

  paged_bx_memory_if #(.RAM_WIDTH(W), .RAM_DEPTH(D), .PAGES(P), .BX_WIDTH(BW)) if_hp ();
  paged_bx_memory_if #(.RAM_WIDTH(W), .RAM_DEPTH(D), .PAGES(P), .BX_WIDTH(BW)) if_ll ();

  assign if_hp.bx_a = bx_a_r;   assign if_ll.bx_a = bx_a_r;
  assign if_hp.wea = wea_r;     assign if_ll.wea = wea_r;
  assign if_hp.dina = dina_r;   assign if_ll.dina = dina_r;
  assign if_hp.bx_b = bx_b_r;   assign if_ll.bx_b = bx_b_r;
  assign if_hp.enb = enb_r;     assign if_ll.enb = enb_r;
  assign if_hp.addrb = addrb_r; assign if_ll.addrb = addrb_r;
  assign if_hp.regceb = regceb_r; assign if_ll.regceb = regceb_r;

  paged_bx_memory #(.RAM_WIDTH(W), .RAM_DEPTH(D), .PAGES(P), .BX_WIDTH(BW),
                    .RAM_PERFORMANCE("HIGH_PERFORMANCE"))
    u_hp (.clk(clk), .reset(rst_n), .bus(if_hp));

  paged_bx_memory #(.RAM_WIDTH(W), .RAM_DEPTH(D), .PAGES(P), .BX_WIDTH(BW),
                    .RAM_PERFORMANCE("LOW_LATENCY"))
    u_ll (.clk(clk), .reset(rst_n), .bus(if_ll));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mem_m [P][D];
  logic         wr_m  [P][D];
  int           cnt_m [P];
  logic [BW-1:0] prev_bx;
  logic         ovf_m;
  logic [W-1:0] ll_d, hp_d;
  logic         ll_v, hp_v, ll_k, hp_k;
  int           m_wp, m_rp, m_c;

  initial begin
    for (int p = 0; p < P; p++)
      for (int a = 0; a < D; a++) wr_m[p][a] = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int p = 0; p < P; p++) cnt_m[p] = 0;
        prev_bx = '0; ovf_m = 1'b0;
        ll_d = '0; ll_v = 1'b0; ll_k = 1'b1;
        hp_d = '0; hp_v = 1'b0; hp_k = 1'b1;
      end else begin
        m_wp = int'(bx_a_r) % P;
        m_rp = int'(bx_b_r) % P;
        if (regceb_r) begin hp_d = ll_d; hp_v = ll_v; hp_k = ll_k; end
        if (enb_r) begin
          ll_d = mem_m[m_rp][addrb_r];
          ll_k = wr_m[m_rp][addrb_r];
          ll_v = int'(addrb_r) < cnt_m[m_rp];
        end else begin
          ll_v = 1'b0;
        end
        m_c = (bx_a_r != prev_bx) ? 0 : cnt_m[m_wp];
        if (bx_a_r != prev_bx) begin cnt_m[m_wp] = 0; ovf_m = 1'b0; end
        if (wea_r) begin
          if (m_c < D) begin
            mem_m[m_wp][m_c] = dina_r;
            wr_m[m_wp][m_c]  = 1'b1;
            cnt_m[m_wp]      = m_c + 1;
          end else begin
            ovf_m = 1'b1;
          end
        end
        prev_bx = bx_a_r;
      end
    end
  end

  // Per-cycle comparison of both copies against the model.
  int e_na, e_nb;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      e_na = (bx_a_r != prev_bx) ? 0 : cnt_m[int'(bx_a_r) % P];
      e_nb = cnt_m[int'(bx_b_r) % P];
      check("hp validb", 64'(if_hp.validb), 64'(hp_v));
      if (hp_k) check("hp doutb", 64'(if_hp.doutb), 64'(hp_d));
      check("ll validb", 64'(if_ll.validb), 64'(ll_v));
      if (ll_k) check("ll doutb", 64'(if_ll.doutb), 64'(ll_d));
      check("hp nent_a", 64'(if_hp.nent_a), 64'(e_na));
      check("ll nent_a", 64'(if_ll.nent_a), 64'(e_na));
      check("hp full_a", 64'(if_hp.full_a), 64'(e_na == D));
      check("hp nent_b", 64'(if_hp.nent_b), 64'(e_nb));
      check("ll nent_b", 64'(if_ll.nent_b), 64'(e_nb));
      check("hp overflow", 64'(if_hp.overflow), 64'(ovf_m));
      check("ll overflow", 64'(if_ll.overflow), 64'(ovf_m));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [BW-1:0] ba, input logic we, input logic [W-1:0] din,
                       input logic [BW-1:0] bb, input logic en, input logic [3:0] ab);
    bx_a_r = ba; wea_r = we; dina_r = din; bx_b_r = bb; enb_r = en; addrb_r = ab;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; regceb_r = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step(3);
    check("reset doutb", 64'(if_hp.doutb), 64'h0);
    check("reset validb", 64'(if_hp.validb), 64'h0);
    check("reset nent_a", 64'(if_hp.nent_a), 64'h0);
    check("reset overflow", 64'(if_hp.overflow), 64'h0);
    rst_n = 1'b1;

    // V1: five appends then reads of addresses 0..5
    for (int i = 0; i < 5; i++) begin drive(0, 1, W'(32'hA0 + i), 0, 0, 0); step(1); end
    drive(0, 0, 0, 0, 0, 0);
    check("v1 nent_a", 64'(if_hp.nent_a), 64'd5);
    for (int a = 0; a < 6; a++) begin
      drive(0, 0, 0, 0, 1, 4'(a)); step(1);
      if (a < 5) check("v1 ll doutb", 64'(if_ll.doutb), 64'(32'hA0 + a));
      check("v1 ll validb", 64'(if_ll.validb), 64'(a < 5));
      drive(0, 0, 0, 0, 0, 0); step(1);
      if (a < 5) check("v1 hp doutb", 64'(if_hp.doutb), 64'(32'hA0 + a));
      check("v1 hp validb", 64'(if_hp.validb), 64'(a < 5));
    end

    // V2: 17 appends on a freshly reset page 0
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, W'(32'hB0 + i), 0, 0, 0); step(1);
      if (i == 15) begin
        check("v2 full_a at 16", 64'(if_hp.full_a), 64'd1);
        check("v2 overflow at 16", 64'(if_hp.overflow), 64'd0);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    check("v2 overflow", 64'(if_hp.overflow), 64'd1);
    check("v2 nent_a", 64'(if_hp.nent_a), 64'd16);
    drive(0, 0, 0, 0, 1, 15); step(1);
    check("v2 last word", 64'(if_ll.doutb), 64'hBF);

    // V3: page change with a same-cycle append
    drive(1, 1, 32'hC0, 0, 0, 0); #1;
    check("v3 nent_a change cycle", 64'(if_hp.nent_a), 64'd0);
    step(1);
    drive(1, 0, 0, 0, 0, 0);
    check("v3 nent_a", 64'(if_hp.nent_a), 64'd1);
    check("v3 overflow cleared", 64'(if_hp.overflow), 64'd0);
    check("v3 page0 nent_b", 64'(if_hp.nent_b), 64'd16);
    drive(1, 1, 32'hC1, 0, 0, 0); step(1);
    drive(1, 1, 32'hC2, 0, 0, 0); step(1);
    drive(1, 1, 32'h11, 0, 0, 0); step(1);
    drive(1, 0, 0, 1, 1, 0); step(1);
    check("v3 page1 addr0", 64'(if_ll.doutb), 64'hC0);

    // V4: bx 2 aliases page 0 and clears it
    drive(2, 0, 0, 0, 0, 0); #1;
    check("v4 nent_a change cycle", 64'(if_hp.nent_a), 64'd0);
    step(1);
    check("v4 page0 nent_b", 64'(if_hp.nent_b), 64'd0);
    drive(2, 0, 0, 0, 1, 0); step(1);
    check("v4 stale data", 64'(if_ll.doutb), 64'hB0);
    check("v4 stale validb", 64'(if_ll.validb), 64'd0);

    // V5: re-enter page 1, rebuild three entries, then collide at addr 3
    drive(3, 1, 32'hD0, 1, 0, 0); step(1);
    drive(3, 1, 32'hD1, 1, 0, 0); step(1);
    drive(3, 1, 32'hD2, 1, 0, 0); step(1);
    drive(3, 1, 32'h22, 1, 1, 3); step(1);
    check("v5 read-first data", 64'(if_ll.doutb), 64'h11);
    check("v5 read-first validb", 64'(if_ll.validb), 64'd0);
    drive(3, 0, 0, 1, 1, 3); step(1);
    check("v5 new data", 64'(if_ll.doutb), 64'h22);
    check("v5 new validb", 64'(if_ll.validb), 64'd1);
    drive(3, 0, 0, 1, 0, 0); step(1);
    check("v5 hp new data", 64'(if_hp.doutb), 64'h22);
    drive(3, 0, 0, 1, 1, 1); step(1);
    drive(3, 0, 0, 1, 0, 0); regceb_r = 1'b0; step(1);
    check("v5 regceb hold", 64'(if_hp.doutb), 64'h22);
    regceb_r = 1'b1; step(1);
    check("v5 regceb load", 64'(if_hp.doutb), 64'hD1);

    // V6: reset while a read is in flight, then latency comparison
    drive(3, 0, 0, 1, 1, 0); step(1);
    check("v6 ll before reset", 64'(if_ll.doutb), 64'hD0);
    rst_n = 1'b0; #1;
    check("v6 hp doutb in reset", 64'(if_hp.doutb), 64'h0);
    check("v6 hp validb in reset", 64'(if_hp.validb), 64'h0);
    check("v6 ll doutb in reset", 64'(if_ll.doutb), 64'h0);
    check("v6 nent_b in reset", 64'(if_hp.nent_b), 64'h0);
    drive(0, 0, 0, 1, 0, 0);
    step(1);
    rst_n = 1'b1; step(1);
    check("v6 hp validb after release", 64'(if_hp.validb), 64'h0);
    check("v6 ll validb after release", 64'(if_ll.validb), 64'h0);
    drive(0, 0, 0, 1, 1, 0); step(1);
    check("v6 ll 1-cycle data", 64'(if_ll.doutb), 64'hD0);
    check("v6 ll validb count0", 64'(if_ll.validb), 64'h0);
    check("v6 hp not yet", 64'(if_hp.doutb), 64'h0);
    drive(0, 0, 0, 1, 0, 0); step(1);
    check("v6 hp 2-cycle data", 64'(if_hp.doutb), 64'hD0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end
endmodule

// File: doc/paged_bx_memory.md
PAGED_BX_MEMORY -- requirements
Module: paged_bx_memory

Interface
REQ-001 The block SHALL have these parameters, one per line:
- RAM_WIDTH, 32, data word width in bits.
- RAM_DEPTH, 16, entries per page; power of two, at least 2.
- PAGES, 2, number of BX pages; power of two, at least 2.
- BX_WIDTH, 3, width of BX inputs; at least clog2(PAGES).
- RAM_PERFORMANCE, "HIGH_PERFORMANCE", read latency: "HIGH_PERFORMANCE" = 2 cycles, "LOW_LATENCY" = 1 cycle.
- Derived: AW = clog2(RAM_DEPTH), PW = clog2(PAGES), NW = AW+1.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- bx_a  in  BX_WIDTH  write-side BX; write page = bx_a[PW-1:0].
- wea  in  1  append request.
- dina  in  RAM_WIDTH  append data.
- bx_b  in  BX_WIDTH  read-side BX; read page = bx_b[PW-1:0].
- enb  in  1  read request.
- addrb  in  AW  read address within the read page.
- regceb  in  1  output-register clock enable; HIGH_PERFORMANCE only.
- doutb  out  RAM_WIDTH  read data.
- validb  out  1  doutb holds an entry that was written.
- nent_b  out  NW  entry count of the read page.
- nent_a  out  NW  entry count of the write page.
- full_a  out  1  write page holds RAM_DEPTH entries.
- overflow  out  1  sticky flag: an append was dropped on the current write page.

Function
REQ-003 Storage SHALL be PAGES x RAM_DEPTH words at physical address {page, addr}, simple dual-port: port A writes, port B reads.
REQ-004 The block SHALL hold one NW-bit entry counter per page.
REQ-005 The block SHALL register bx_a into bx_a_q every cycle; new_bx = (bx_a != bx_a_q).
REQ-006 When new_bx is high, the counter of page bx_a[PW-1:0] SHALL be treated as 0 in that same cycle, and overflow SHALL clear.
REQ-007 On wea with counter < RAM_DEPTH: write dina at {page, counter}, and the counter SHALL increment at the next edge.
REQ-008 When new_bx and wea occur in the same cycle, the write SHALL go to address 0 and the counter SHALL become 1.
REQ-009 On wea with counter == RAM_DEPTH: no write, counter holds, overflow SHALL set at the next edge and stay set until new_bx or reset.
REQ-010 nent_a and full_a SHALL be combinational from the registered counter of bx_a's page, with the new_bx zeroing of REQ-006 applied.
REQ-011 nent_b SHALL be combinational from the registered counter of bx_b's page.
REQ-012 Read, LOW_LATENCY: on enb, doutb and validb SHALL update one cycle later.
REQ-013 Read, HIGH_PERFORMANCE: the RAM register SHALL capture on enb, and the output register SHALL load on regceb one cycle later; total latency 2 cycles.
REQ-014 validb SHALL be (addrb < nent_b at the request cycle) AND enb, pipelined with the data; it SHALL follow the same regceb gating as doutb.
REQ-015 With enb low, doutb SHALL hold its value and validb SHALL drop to 0 at the same latency.
REQ-016 Same page and same address written and read in one cycle SHALL return the old data (read-first), with validb computed from the pre-write counter.
REQ-017 Reads and writes on different pages SHALL be fully independent.
REQ-018 Page index SHALL wrap modulo PAGES: bx 0 and bx PAGES alias the same page, and the new_bx clear applies on re-entry.

Reset
REQ-019 While reset is low, asynchronously: all counters 0, bx_a_q 0, doutb 0, validb 0, overflow 0, pipeline registers 0; RAM contents are unchanged.
REQ-020 A reset mid-operation SHALL discard in-flight reads: validb is 0 on the first edge after release.
REQ-021 After release, with bx_a = 0 there is no new_bx, and counters are already 0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- V1: reset; bx_a = 0; append 5 words 0xA0..0xA4 -> nent_a = 5; read bx_b = 0, addr 0..5 (HIGH_PERFORMANCE, regceb = 1) -> data 0xA0..0xA4 with validb = 1, addr 5 validb = 0, each 2 cycles after enb.
- V2: append 17 words on page 0 (depth 16) -> full_a = 1 after the 16th; the 17th is dropped; overflow = 1; nent_a = 16.
- V3: bx_a 0 -> 1 with wea in the change cycle -> word at page 1 addr 0, nent_a = 1, overflow cleared; page 0 count unchanged when read via bx_b = 0.
- V4: bx_a steps 1 -> 2 (PAGES = 2, aliases page 0) -> page 0 count cleared to 0; old data is still in RAM but validb = 0 for all addresses.
- V5: same-cycle write/read at page 1 addr 3 over old 0x11, new 0x22 -> doutb = 0x11 with validb = 0; the next read -> 0x22 with validb = 1.
- V6: reset asserted between enb and output -> doutb = 0, validb = 0; counters 0; rerun with LOW_LATENCY -> 1-cycle latency.
